max_pool: RTL and testbench

MAX_POOL -- requirements
Module: max_pool

---
 rtl/max_pool.sv | 127 ++++++++++++
 tb/tb_max_pool.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/max_pool.sv
// 2x2 / stride-2 signed max pooling over a raster-ordered IN_DIM x IN_DIM stream.
// Optional macro MAX_POOL_RELU_EN clamps negative pooled results to zero.
module max_pool #(
   parameter int PP     = 8,
   parameter int IN_DIM = 28
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [PP:0]   pxl_in,
   input  logic          in_valid,
   output logic [PP:0]   pool_out,
   output logic          out_valid,
   output logic          frame_done
);

   localparam int W   = PP + 1;
   localparam int HW  = IN_DIM / 2;
   localparam int HCW = (HW > 1) ? $clog2(HW) : 1;
   // One extra bit over the half-column index always covers IN_DIM-1.
   localparam int CW  = HCW + 1;
   localparam logic [CW-1:0] LAST_C = CW'(IN_DIM - 1);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   function automatic logic [W-1:0] smax(input logic [W-1:0] a, input logic [W-1:0] b);
      if ($signed(a) >= $signed(b)) begin
         return a;
      end else begin
         return b;
      end
   endfunction

   function automatic logic [W-1:0] out_sel(input logic [W-1:0] v);
`ifdef MAX_POOL_RELU_EN
      if (v[W-1]) begin
         return {W{1'b0}};
      end else begin
         return v;
      end
`else
      return v;
`endif
   endfunction

   logic [CW-1:0]  col_q, col_d, row_q, row_d;
   logic [W-1:0]   partial_q, partial_d;
   logic [W-1:0]   pool_q, pool_d;
   logic           out_valid_q, out_valid_d;
   logic           frame_done_q, frame_done_d;
   logic [W-1:0]   lb_q [HW];
   logic           lb_we_s;
   logic [W-1:0]   lb_wdata_s;
   logic [HCW-1:0] half_col_s;
   logic [W-1:0]   win_max_s;

   // Next-state: window phase decode, line-buffer write and raster counters
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      partial_d    = partial_q;
      pool_d       = pool_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      lb_we_s      = 1'b0;
      lb_wdata_s   = {W{1'b0}};
      half_col_s   = col_q[CW-1:1];
      win_max_s    = smax(smax(lb_q[half_col_s], partial_q), pxl_in);
      if (in_valid) begin
         case ({row_q[0], col_q[0]})
            2'b00: partial_d = pxl_in;
            2'b01: begin
               lb_we_s    = 1'b1;
               lb_wdata_s = smax(partial_q, pxl_in);
            end
            2'b10: partial_d = pxl_in;
            2'b11: begin
               pool_d       = out_sel(win_max_s);
               out_valid_d  = 1'b1;
               frame_done_d = (row_q == LAST_C) && (col_q == LAST_C);
            end
            default: partial_d = partial_q;
         endcase
         if (col_q == LAST_C) begin
            col_d = {CW{1'b0}};
            if (row_q == LAST_C) begin
               row_d = {CW{1'b0}};
            end else begin
               row_d = row_q + ONE_C;
            end
         end else begin
            col_d = col_q + ONE_C;
         end
      end else begin
         out_valid_d = 1'b0;
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q        <= {CW{1'b0}};
         row_q        <= {CW{1'b0}};
         partial_q    <= {W{1'b0}};
         pool_q       <= {W{1'b0}};
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         partial_q    <= partial_d;
         pool_q       <= pool_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffer of even-row pair maxima; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (lb_we_s) begin
         lb_q[half_col_s] <= lb_wdata_s;
      end
   end

   assign pool_out   = pool_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_max_pool.sv
// Randomised + directed bench for max_pool: a 4x4 instance and a default 28x28 instance,
// each checked every cycle against a frame-image reference model.
module tb_max_pool;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              iv [2];
   logic signed [8:0] px [2];
   logic signed [8:0] po [2];
   logic              ov [2];
   logic              fd [2];

   int errors = 0;
   int checks = 0;

   int k   [2] = '{0, 0};
   bit ev  [2] = '{1'b0, 1'b0};
   bit ef  [2] = '{1'b0, 1'b0};
   int ex  [2] = '{0, 0};
   int img [2][28][28];
   int mn, mr, mc;

   int got4 [$];
   int fd4 = 0, fd4_at = 0;
   int res28 = 0, fd28 = 0, fd28_at = 0;

   max_pool #(.PP(8), .IN_DIM(4)) dut4 (
      .clk(clk), .reset(reset), .pxl_in(px[0]), .in_valid(iv[0]),
      .pool_out(po[0]), .out_valid(ov[0]), .frame_done(fd[0])
   );

   max_pool #(.PP(8), .IN_DIM(28)) dut28 (
      .clk(clk), .reset(reset), .pxl_in(px[1]), .in_valid(iv[1]),
      .pool_out(po[1]), .out_valid(ov[1]), .frame_done(fd[1])
   );

   always #5 clk = ~clk;

   function automatic int max2(int a, int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int relu_m(int v);
`ifdef MAX_POOL_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   // Reference: store accepted samples in a frame image; a pooled result is due the cycle after
   // each bottom-right window sample is accepted.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            k[d] = 0; ev[d] = 1'b0; ef[d] = 1'b0; ex[d] = 0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            ev[d] = 1'b0;
            ef[d] = 1'b0;
            if (iv[d]) begin
               mn = (d == 0) ? 4 : 28;
               mr = k[d] / mn;
               mc = k[d] % mn;
               img[d][mr][mc] = int'(px[d]);
               if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                  ex[d] = relu_m(max2(max2(img[d][mr-1][mc-1], img[d][mr-1][mc]),
                                      max2(img[d][mr][mc-1], img[d][mr][mc])));
                  ev[d] = 1'b1;
                  ef[d] = (k[d] == mn * mn - 1);
               end
               k[d] = (k[d] + 1) % (mn * mn);
            end
         end
      end
   end

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: compare both DUTs against the model on the falling edge, then allow driving.
   task automatic tick();
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         if (!reset) begin
            chk($sformatf("dut%0d quiet_in_reset", d), (ov[d] || fd[d] || po[d] != 9'sd0) ? 1 : 0, 0);
         end else begin
            chk($sformatf("dut%0d out_valid", d), int'(ov[d]), int'(ev[d]));
            if (ev[d]) begin
               chk($sformatf("dut%0d pool_out", d), int'(po[d]), ex[d]);
               chk($sformatf("dut%0d frame_done", d), int'(fd[d]), int'(ef[d]));
            end else begin
               chk($sformatf("dut%0d frame_done_idle", d), int'(fd[d]), 0);
            end
            if (ov[d]) begin
               if (d == 0) begin
                  got4.push_back(int'(po[d]));
                  if (fd[d]) begin fd4++; fd4_at = got4.size(); end
               end else begin
                  res28++;
                  if (fd[d]) begin fd28++; fd28_at = res28; end
               end
            end
         end
      end
      #1;
   endtask

   task automatic drive(int d, int v);
      tick();
      iv[0] = 1'b0;
      iv[1] = 1'b0;
      iv[d] = 1'b1;
      px[d] = 9'(v);
   endtask

   task automatic idle();
      tick();
      iv[0] = 1'b0;
      iv[1] = 1'b0;
   endtask

   task automatic clear4();
      got4.delete();
      fd4 = 0;
      fd4_at = 0;
   endtask

   task automatic check_list(string nm, int e[$]);
      chk({nm, " count"}, got4.size(), e.size());
      for (int i = 0; i < e.size() && i < got4.size(); i++) begin
         chk($sformatf("%s result%0d", nm, i), got4[i], e[i]);
      end
   endtask

   initial begin
      int e[$];
      int acc;
      int v;
      iv[0] = 1'b0; iv[1] = 1'b0;
      px[0] = 9'sd0; px[1] = 9'sd0;

      // reset state
      repeat (3) tick();
      chk("reset pool_out", int'(po[0]), 0);
      chk("reset out_valid", int'(ov[1]), 0);
      reset = 1'b1;
      repeat (2) idle();

      // raster 0..15
      clear4();
      for (int i = 0; i < 16; i++) drive(0, i);
      repeat (3) idle();
      e = {5, 7, 13, 15};
      check_list("ramp", e);
      chk("ramp frame_done count", fd4, 1);
      chk("ramp frame_done on last", fd4_at, 4);

      // negative window
      clear4();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            v = -8;
            if (r == 0 && c == 0) v = -3;
            if (r == 0 && c == 1) v = -1;
            if (r == 1 && c == 0) v = -7;
            if (r == 1 && c == 1) v = -2;
            drive(0, v);
         end
      end
      repeat (3) idle();
`ifdef MAX_POOL_RELU_EN
      e = {0, 0, 0, 0};
`else
      e = {-1, -8, -8, -8};
`endif
      check_list("negative", e);

      // gaps every other cycle
      clear4();
      for (int i = 0; i < 16; i++) begin
         drive(0, i);
         idle();
      end
      repeat (3) idle();
      e = {5, 7, 13, 15};
      check_list("gapped", e);
      chk("gapped frame_done on last", fd4_at, 4);

      // two frames back to back
      clear4();
      for (int i = 0; i < 32; i++) drive(0, i);
      repeat (3) idle();
      e = {5, 7, 13, 15, 21, 23, 29, 31};
      check_list("b2b", e);
      chk("b2b frame_done count", fd4, 2);
      chk("b2b second frame_done position", fd4_at, 8);

      // reset mid-frame
      for (int i = 0; i < 6; i++) drive(0, 50 + i);
      tick();
      reset = 1'b0;
      iv[0] = 1'b0;
      iv[1] = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      clear4();
      repeat (2) idle();
      chk("post-reset no stray pulse", got4.size(), 0);
      for (int i = 0; i < 16; i++) drive(0, i);
      repeat (3) idle();
      e = {5, 7, 13, 15};
      check_list("after_reset", e);
      chk("after_reset frame_done count", fd4, 1);

      // default-size random frame with random gaps
      acc = 0;
      while (acc < 784) begin
         if ($urandom_range(0, 3) != 0) begin
            drive(1, int'($urandom_range(0, 511)));
            acc++;
         end else begin
            idle();
         end
      end
      repeat (4) idle();
      chk("random result count", res28, 196);
      chk("random frame_done count", fd28, 1);
      chk("random frame_done on 196th", fd28_at, 196);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
